// File: rtl/jerry_pkg.sv
// Shared types and constants for the Jerry sprite animation controller.
// Used by jerry_anim_ctrl and anim_step_counter.
package jerry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    AIR
  } jerry_anim_state_t;

  localparam int unsigned SC_DIR     = 6;
  localparam int unsigned SC_AIR     = 5;
  localparam int unsigned SC_IDLE    = 4;
  localparam int unsigned RUN_FRAMES = 8;
  localparam int unsigned FRAME_W    = $clog2(RUN_FRAMES);

  localparam logic [6:0] SC_RESET = 7'h50;

  // Builds the sprite_control word from the current state, facing and run frame.
  function automatic logic [6:0] encode_sc(input jerry_anim_state_t state, input logic dir,
                                           input logic [FRAME_W-1:0] frame);
    logic [6:0] sc;
    sc         = '0;
    sc[SC_DIR] = dir;
    unique case (state)
      IDLE:    sc[SC_IDLE] = 1'b1;
      RUN:     sc[FRAME_W-1:0] = frame;
      AIR:     sc[SC_AIR] = 1'b1;
      default: sc = SC_RESET;
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/anim_step_counter.sv
// Run-cycle step divider and frame index: frame advances once every
// FRAMES_PER_STEP enabled ticks and wraps after RUN_FRAMES images.
module anim_step_counter
  import jerry_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [FRAME_W-1:0] frame
);

  localparam int unsigned DivW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FRAMES_PER_STEP - 1);

  logic [DivW-1:0]    div_q, div_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (clr) begin
      div_d   = '0;
      frame_d = '0;
    end else if (en) begin
      if (div_q == DivLast) begin
        div_d   = '0;
        frame_d = frame_q + FRAME_W'(1);
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/jerry_anim_ctrl.sv
// Jerry animation controller: facing, idle/run/air state and run-cycle frame -> sprite_control.
// Optional JERRY_TURN_RESTART_EN restarts the run cycle on a direction reversal while running.
module jerry_anim_ctrl
  import jerry_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       airborne,
  output logic [6:0] sprite_control
);

  jerry_anim_state_t  state_q, state_d;
  logic               dir_q, dir_d;
  logic               go_right, go_left;
  logic               stay_run, restart;
  logic               cnt_en, cnt_clr;
  logic [FRAME_W-1:0] frame;

  // Both or neither held counts as no movement.
  assign go_right = move_right & ~move_left;
  assign go_left  = move_left & ~move_right;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (frame_tick) begin
      if (go_right) begin
        dir_d = 1'b1;
      end else if (go_left) begin
        dir_d = 1'b0;
      end
      if (airborne) begin
        state_d = AIR;
      end else if (go_right || go_left) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign stay_run = (state_q == RUN) && (state_d == RUN);

`ifdef JERRY_TURN_RESTART_EN
  assign restart = stay_run && (dir_d != dir_q);
`else
  assign restart = 1'b0;
`endif

  // Any tick that does not continue an existing run resets the cycle to frame 0.
  assign cnt_en  = frame_tick & stay_run & ~restart;
  assign cnt_clr = frame_tick & (~stay_run | restart);

  anim_step_counter #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_step_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .frame(frame)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign sprite_control = encode_sc(state_q, dir_q, frame);

endmodule
